// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter for the shared video RAM port.
// Round-robin or m0-priority, burst-held grant, stalled-slave watchdog.
module wb_ram_arbiter #(
  parameter int TIMEOUT     = 256,
  parameter bit M0_PRIORITY = 1'b0
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        p_m0_wb_CYC_I,
  input  logic        p_m0_wb_STB_I,
  input  logic        p_m0_wb_WE_I,
  input  logic        p_m0_wb_LOCK_I,
  input  logic [31:0] p_m0_wb_ADR_I,
  input  logic [31:0] p_m0_wb_DAT_I,
  input  logic [3:0]  p_m0_wb_SEL_I,
  output logic [31:0] p_m0_wb_DAT_O,
  output logic        p_m0_wb_ACK_O,
  output logic        p_m0_wb_ERR_O,
  output logic        p_m0_wb_RTY_O,
  input  logic        p_m1_wb_CYC_I,
  input  logic        p_m1_wb_STB_I,
  input  logic        p_m1_wb_WE_I,
  input  logic        p_m1_wb_LOCK_I,
  input  logic [31:0] p_m1_wb_ADR_I,
  input  logic [31:0] p_m1_wb_DAT_I,
  input  logic [3:0]  p_m1_wb_SEL_I,
  output logic [31:0] p_m1_wb_DAT_O,
  output logic        p_m1_wb_ACK_O,
  output logic        p_m1_wb_ERR_O,
  output logic        p_m1_wb_RTY_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  output logic        p_wb_LOCK_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  output logic [3:0]  p_wb_SEL_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I,
  output logic [1:0]  p_grant,
  output logic        p_timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN0  = 2'd1;
  localparam logic [1:0] OWN1  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_owner;
  logic          abort_owner;
  logic          abort_first;
  logic [WW-1:0] wdog;

  logic sel0, sel1, active, cur;
  logic cur_cyc, cur_stb, resp, pick;

  assign sel0    = (state == OWN0);
  assign sel1    = (state == OWN1);
  assign active  = sel0 | sel1;
  assign cur     = sel1 | ((state == ABORT) & abort_owner);
  assign cur_cyc = cur ? p_m1_wb_CYC_I : p_m0_wb_CYC_I;
  assign cur_stb = cur ? p_m1_wb_STB_I : p_m0_wb_STB_I;
  assign resp    = p_wb_ACK_I | p_wb_ERR_I | p_wb_RTY_I;
  // On contention: fixed m0 win, or whoever did not own the bus last
  assign pick    = M0_PRIORITY ? 1'b0 : ~last_owner;

  assign p_grant = {cur & (state != IDLE), ~cur & (state != IDLE)};
  assign p_timeout = abort_first;

  // Slave side is only driven while a master owns the bus outright
  assign p_wb_CYC_O  = active & cur_cyc;
  assign p_wb_STB_O  = active & cur_stb;
  assign p_wb_WE_O   = active & (cur ? p_m1_wb_WE_I : p_m0_wb_WE_I);
  assign p_wb_LOCK_O = active & (cur ? p_m1_wb_LOCK_I : p_m0_wb_LOCK_I);
  assign p_wb_ADR_O  = !active ? 32'd0 :
                       cur ? p_m1_wb_ADR_I : p_m0_wb_ADR_I;
  assign p_wb_DAT_O  = !active ? 32'd0 :
                       cur ? p_m1_wb_DAT_I : p_m0_wb_DAT_I;
  assign p_wb_SEL_O  = !active ? 4'd0 :
                       cur ? p_m1_wb_SEL_I : p_m0_wb_SEL_I;

  assign p_m0_wb_DAT_O = sel0 ? p_wb_DAT_I : 32'd0;
  assign p_m0_wb_ACK_O = sel0 & p_wb_ACK_I;
  assign p_m0_wb_RTY_O = sel0 & p_wb_RTY_I;
  assign p_m0_wb_ERR_O = (sel0 & p_wb_ERR_I) |
                         (abort_first & ~abort_owner);

  assign p_m1_wb_DAT_O = sel1 ? p_wb_DAT_I : 32'd0;
  assign p_m1_wb_ACK_O = sel1 & p_wb_ACK_I;
  assign p_m1_wb_RTY_O = sel1 & p_wb_RTY_I;
  assign p_m1_wb_ERR_O = (sel1 & p_wb_ERR_I) |
                         (abort_first & abort_owner);

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      abort_owner <= 1'b0;
      abort_first <= 1'b0;
      wdog        <= '0;
    end else begin
      abort_first <= 1'b0;
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (p_m0_wb_CYC_I && p_m1_wb_CYC_I)
            state <= pick ? OWN1 : OWN0;
          else if (p_m0_wb_CYC_I)
            state <= OWN0;
          else if (p_m1_wb_CYC_I)
            state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!cur_cyc) begin
            state      <= IDLE;
            last_owner <= cur;
            wdog       <= '0;
          end else if (cur_stb && !resp) begin
            if (wdog == WD_MAX) begin
              state       <= ABORT;
              abort_owner <= cur;
              abort_first <= 1'b1;
              wdog        <= '0;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end else begin
            wdog <= '0;
          end
        end
        default: begin
          wdog <= '0;
          if (!cur_cyc) begin
            state      <= IDLE;
            last_owner <= cur;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: bursts, arbitration,
// watchdog abort, ack-at-limit and mid-burst reset.
module tb_wb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cyc, m0_stb, m0_we, m0_lock;
  logic [31:0] m0_adr, m0_dat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_lock;
  logic [31:0] m1_adr, m1_dat;
  logic [3:0]  m1_sel;

  logic        auto_ack, man_ack, man_err;

  logic [31:0] d0_dat, d1_dat, s_adr, s_dat, s_dati;
  logic        d0_ack, d0_err, d0_rty, d1_ack, d1_err, d1_rty;
  logic        s_cyc, s_stb, s_we, s_lock, s_ack;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic        tmo;

  logic [31:0] pd0_dat, pd1_dat, ps_adr, ps_dat;
  logic        pd0_ack, pd0_err, pd0_rty, pd1_ack, pd1_err, pd1_rty;
  logic        ps_cyc, ps_stb, ps_we, ps_lock, ps_ack;
  logic [3:0]  ps_sel;
  logic [1:0]  pgrant;
  logic        ptmo;

  assign s_dati = s_adr ^ 32'hA5A5_A5A5;
  assign s_ack  = (auto_ack & s_cyc & s_stb) | man_ack;
  assign ps_ack = auto_ack & ps_cyc & ps_stb;

  wb_ram_arbiter #(.TIMEOUT(16), .M0_PRIORITY(1'b0)) dut (
    .p_clk(clk), .p_resetn(rst_n),
    .p_m0_wb_CYC_I(m0_cyc), .p_m0_wb_STB_I(m0_stb),
    .p_m0_wb_WE_I(m0_we), .p_m0_wb_LOCK_I(m0_lock),
    .p_m0_wb_ADR_I(m0_adr), .p_m0_wb_DAT_I(m0_dat),
    .p_m0_wb_SEL_I(m0_sel), .p_m0_wb_DAT_O(d0_dat),
    .p_m0_wb_ACK_O(d0_ack), .p_m0_wb_ERR_O(d0_err),
    .p_m0_wb_RTY_O(d0_rty),
    .p_m1_wb_CYC_I(m1_cyc), .p_m1_wb_STB_I(m1_stb),
    .p_m1_wb_WE_I(m1_we), .p_m1_wb_LOCK_I(m1_lock),
    .p_m1_wb_ADR_I(m1_adr), .p_m1_wb_DAT_I(m1_dat),
    .p_m1_wb_SEL_I(m1_sel), .p_m1_wb_DAT_O(d1_dat),
    .p_m1_wb_ACK_O(d1_ack), .p_m1_wb_ERR_O(d1_err),
    .p_m1_wb_RTY_O(d1_rty),
    .p_wb_CYC_O(s_cyc), .p_wb_STB_O(s_stb), .p_wb_WE_O(s_we),
    .p_wb_LOCK_O(s_lock), .p_wb_ADR_O(s_adr), .p_wb_DAT_O(s_dat),
    .p_wb_SEL_O(s_sel), .p_wb_DAT_I(s_dati), .p_wb_ACK_I(s_ack),
    .p_wb_ERR_I(man_err), .p_wb_RTY_I(1'b0),
    .p_grant(grant), .p_timeout(tmo)
  );

  wb_ram_arbiter #(.TIMEOUT(16), .M0_PRIORITY(1'b1)) dut_p (
    .p_clk(clk), .p_resetn(rst_n),
    .p_m0_wb_CYC_I(m0_cyc), .p_m0_wb_STB_I(m0_stb),
    .p_m0_wb_WE_I(m0_we), .p_m0_wb_LOCK_I(m0_lock),
    .p_m0_wb_ADR_I(m0_adr), .p_m0_wb_DAT_I(m0_dat),
    .p_m0_wb_SEL_I(m0_sel), .p_m0_wb_DAT_O(pd0_dat),
    .p_m0_wb_ACK_O(pd0_ack), .p_m0_wb_ERR_O(pd0_err),
    .p_m0_wb_RTY_O(pd0_rty),
    .p_m1_wb_CYC_I(m1_cyc), .p_m1_wb_STB_I(m1_stb),
    .p_m1_wb_WE_I(m1_we), .p_m1_wb_LOCK_I(m1_lock),
    .p_m1_wb_ADR_I(m1_adr), .p_m1_wb_DAT_I(m1_dat),
    .p_m1_wb_SEL_I(m1_sel), .p_m1_wb_DAT_O(pd1_dat),
    .p_m1_wb_ACK_O(pd1_ack), .p_m1_wb_ERR_O(pd1_err),
    .p_m1_wb_RTY_O(pd1_rty),
    .p_wb_CYC_O(ps_cyc), .p_wb_STB_O(ps_stb), .p_wb_WE_O(ps_we),
    .p_wb_LOCK_O(ps_lock), .p_wb_ADR_O(ps_adr), .p_wb_DAT_O(ps_dat),
    .p_wb_SEL_O(ps_sel), .p_wb_DAT_I(32'd0), .p_wb_ACK_I(ps_ack),
    .p_wb_ERR_I(1'b0), .p_wb_RTY_I(1'b0),
    .p_grant(pgrant), .p_timeout(ptmo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0;
    m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0;
    m1_adr = 0; m1_dat = 0; m1_sel = 0;
    auto_ack = 0; man_ack = 0; man_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    n_cmp++;
    if (grant !== 2'b00 || tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grant got=%b/%b want=00/0", grant, tmo);
    end
    n_cmp++;
    if ({s_cyc, s_stb, s_we, s_lock, s_sel} !== 8'd0 ||
        s_adr !== 32'd0 || s_dat !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_slave got cyc=%b adr=%h want 0", s_cyc, s_adr);
    end
    n_cmp++;
    if ({d0_ack, d0_err, d0_rty, d1_ack, d1_err, d1_rty} !== 6'd0 ||
        d0_dat !== 32'd0 || d1_dat !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_master got ack0=%b ack1=%b want 0", d0_ack, d1_ack);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_burst();
    int acks = 0;
    bit other = 0;
    bit adr_ok = 1;
    do_reset();
    auto_ack = 1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h4100_0000; m0_dat = 32'h1000_0000;
    #1;
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL burst_pregrant got=%b want=00", grant);
    end
    step();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL burst_grant got=%b want=01", grant);
    end
    for (int i = 0; i < 8; i++) begin
      m0_adr = 32'h4100_0000 + 32'(4 * i);
      m0_dat = 32'h1000_0000 + 32'(i);
      #1;
      if (d0_ack === 1'b1) acks++;
      if (s_adr !== m0_adr || s_dat !== m0_dat || s_we !== 1'b1)
        adr_ok = 0;
      if ({d1_ack, d1_err, d1_rty} !== 3'd0 || d1_dat !== 32'd0)
        other = 1;
      step();
    end
    m0_cyc = 0; m0_stb = 0;
    #1;
    n_cmp++;
    if (acks !== 8) begin
      n_bad++;
      $display("FAIL burst_acks got=%0d want=8", acks);
    end
    n_cmp++;
    if (adr_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_mux got=%b want=1", adr_ok);
    end
    n_cmp++;
    if (other !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_m1_quiet got=%b want=0", other);
    end
    step();
    n_cmp++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_release got=%b/%b want=00/0", grant, s_cyc);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    auto_ack = 1;
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    step();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL rr_first got=%b want=01", grant);
    end
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL rr_idle_gap got=%b want=00", grant);
    end
    step();
    n_cmp++;
    if (grant !== 2'b10 || d1_dat !== (32'h200 ^ 32'hA5A5_A5A5)) begin
      n_bad++;
      $display("FAIL rr_second got=%b dat=%h want=10 %h",
               grant, d1_dat, 32'h200 ^ 32'hA5A5_A5A5);
    end
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 0; m1_stb = 0;
    step();
    m1_cyc = 1; m1_stb = 1;
    step();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL rr_third got=%b want=01", grant);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1;
    step();
    n_cmp++;
    if (grant !== 2'b10) begin
      n_bad++;
      $display("FAIL rr_fourth got=%b want=10", grant);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_priority();
    do_reset();
    auto_ack = 1;
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1;
    step();
    for (int r = 0; r < 3; r++) begin
      m0_cyc = 0;
      step();
      n_cmp++;
      if (pgrant !== 2'b00) begin
        n_bad++;
        $display("FAIL prio_gap%0d got=%b want=00", r, pgrant);
      end
      m0_cyc = 1;
      step();
      n_cmp++;
      if (pgrant !== 2'b01) begin
        n_bad++;
        $display("FAIL prio_win%0d got=%b want=01", r, pgrant);
      end
      if (r == 0) begin
        n_cmp++;
        if (grant !== 2'b10) begin
          n_bad++;
          $display("FAIL prio_rr_ref got=%b want=10", grant);
        end
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    bit early = 0;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    step();
    for (int i = 0; i < 16; i++) begin
      if (d0_err !== 1'b0 || tmo !== 1'b0 || s_cyc !== 1'b1) early = 1;
      step();
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early got=%b want=0", early);
    end
    n_cmp++;
    if (d0_err !== 1'b1 || tmo !== 1'b1 || d1_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_abort got err=%b tmo=%b want 1/1", d0_err, tmo);
    end
    n_cmp++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_cyc got=%b want=0", s_cyc);
    end
    man_ack = 1;
    #1;
    n_cmp++;
    if (d0_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_late_ack got=%b want=0", d0_ack);
    end
    step();
    n_cmp++;
    if (d0_err !== 1'b0 || tmo !== 1'b0 || s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_hold got err=%b tmo=%b cyc=%b want 0",
               d0_err, tmo, s_cyc);
    end
    man_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    step();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL tmo_release got=%b want=00", grant);
    end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    repeat (15) step();
    man_ack = 1;
    #1;
    n_cmp++;
    if (d0_ack !== 1'b1 || d0_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lim_ack got ack=%b err=%b want 1/0", d0_ack, d0_err);
    end
    step();
    man_ack = 0;
    #1;
    n_cmp++;
    if (tmo !== 1'b0 || d0_err !== 1'b0 ||
        grant !== 2'b01 || s_cyc !== 1'b1) begin
      n_bad++;
      $display("FAIL lim_noabort got tmo=%b err=%b g=%b want 0/0/01",
               tmo, d0_err, grant);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    m0_cyc = 1;
    step();
    m0_cyc = 0;
    #1;
    n_cmp++;
    if (grant !== 2'b01 || s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_grant got=%b cyc=%b want=01/0", grant, s_cyc);
    end
    step();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL wd_release got=%b want=00", grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_ack = 1;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100;
    step();
    #1;
    n_cmp++;
    if (d1_ack !== 1'b1 || d0_ack !== 1'b0 ||
        d1_dat !== (32'h100 ^ 32'hA5A5_A5A5)) begin
      n_bad++;
      $display("FAIL mid_read got ack=%b dat=%h want 1 %h",
               d1_ack, d1_dat, 32'h100 ^ 32'hA5A5_A5A5);
    end
    man_err = 1;
    #1;
    n_cmp++;
    if (d1_err !== 1'b1 || d0_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_err_route got=%b%b want=10", d1_err, d0_err);
    end
    man_err = 0;
    step();
    rst_n = 0;
    #1;
    n_cmp++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 ||
        grant !== 2'b00 || d1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got cyc=%b stb=%b g=%b ack=%b want 0",
               s_cyc, s_stb, grant, d1_ack);
    end
    clear_inputs();
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_burst();
    test_round_robin();
    test_priority();
    test_timeout();
    test_ack_at_limit();
    test_withdraw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
